// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and arbiter state encoding for the uart transmit path
package uart_pkg;
    localparam int DATA_W = 7;
    typedef enum logic [1:0] {IDLE, FLUSH, WAIT_BUSY, WAIT_DONE} arb_state_t;
endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin picker, first set request at or above rr_ptr with wrap
module uart_rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] rr_ptr,
    output logic                     any,
    output logic [$clog2(N_REQ)-1:0] winner
);
    localparam int IW = $clog2(N_REQ);

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] p, input int k);
        logic [IW:0] s;
        s = {1'b0, p} + (IW+1)'(k);
        return (s >= (IW+1)'(N_REQ)) ? IW'(s - (IW+1)'(N_REQ)) : s[IW-1:0];
    endfunction

    // Scan from the farthest offset down so the nearest requester is written last and wins.
    always_comb begin
        any = 1'b0;
        winner = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[wrap_idx(rr_ptr, k)]) begin
                any = 1'b1;
                winner = wrap_idx(rr_ptr, k);
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx between N_REQ character producers,
// holding each grant until the transmitter's busy frame completes or fails to start.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int DATA_W        = uart_pkg::DATA_W,
    parameter int START_TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*DATA_W-1:0]  req_data,
    output logic [N_REQ-1:0]         req_ack,
    output logic [DATA_W-1:0]        to_sent,
    output logic                     flush,
    input  logic                     busy,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     active,
    output logic                     timeout_err
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(START_TIMEOUT);

    arb_state_t        state_q, state_d;
    logic [DATA_W-1:0] to_sent_q, to_sent_d;
    logic              flush_q, flush_d;
    logic [N_REQ-1:0]  req_ack_q, req_ack_d;
    logic [IW-1:0]     grant_id_q, grant_id_d;
    logic              active_q, active_d;
    logic              timeout_err_q, timeout_err_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              any;
    logic [IW-1:0]     winner;

    uart_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req    (req_valid),
        .rr_ptr (rr_ptr_q),
        .any    (any),
        .winner (winner)
    );

    always_comb begin
        state_d       = state_q;
        to_sent_d     = to_sent_q;
        flush_d       = 1'b0;
        req_ack_d     = '0;
        grant_id_d    = grant_id_q;
        active_d      = active_q;
        timeout_err_d = 1'b0;
        rr_ptr_d      = rr_ptr_q;
        cnt_d         = cnt_q;
        case (state_q)
            IDLE: begin
                if (!busy && any) begin
                    to_sent_d  = req_data[winner*DATA_W +: DATA_W];
                    grant_id_d = winner;
                    req_ack_d  = N_REQ'(1) << winner;
                    flush_d    = 1'b1;
                    active_d   = 1'b1;
                    rr_ptr_d   = (winner == IW'(N_REQ - 1)) ? '0 : winner + 1'b1;
                    state_d    = FLUSH;
                end
            end
            FLUSH: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CW'(START_TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    active_d      = 1'b0;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!busy) begin
                    active_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            to_sent_q     <= '0;
            flush_q       <= 1'b0;
            req_ack_q     <= '0;
            grant_id_q    <= '0;
            active_q      <= 1'b0;
            timeout_err_q <= 1'b0;
            rr_ptr_q      <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            to_sent_q     <= to_sent_d;
            flush_q       <= flush_d;
            req_ack_q     <= req_ack_d;
            grant_id_q    <= grant_id_d;
            active_q      <= active_d;
            timeout_err_q <= timeout_err_d;
            rr_ptr_q      <= rr_ptr_d;
            cnt_q         <= cnt_d;
        end
    end

    assign to_sent     = to_sent_q;
    assign flush       = flush_q;
    assign req_ack     = req_ack_q;
    assign grant_id    = grant_id_q;
    assign active      = active_q;
    assign timeout_err = timeout_err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed tests of the arbiter against a busy-frame model of uart_tx
module tb_uart_tx_arbiter;
    localparam int FRAME = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [27:0] req_data = '0;
    logic [3:0]  req_ack;
    logic [6:0]  to_sent;
    logic        flush;
    logic        busy;
    logic [1:0]  grant_id;
    logic        active;
    logic        timeout_err;

    logic stub_en = 1'b1;
    logic busy_man = 1'b0;
    int   busy_cnt = 0;
    int   cyc = 0;
    int   fall_cyc = 0;
    int   viol = 0;
    logic busy_prev = 1'b0;
    int   checks = 0;
    int   failures = 0;

    uart_tx_arbiter #(.N_REQ(4), .DATA_W(7), .START_TIMEOUT(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ack     (req_ack),
        .to_sent     (to_sent),
        .flush       (flush),
        .busy        (busy),
        .grant_id    (grant_id),
        .active      (active),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    assign busy = stub_en ? (busy_cnt != 0) : busy_man;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (stub_en && flush) busy_cnt <= FRAME;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    always @(negedge clk) begin
        busy_prev <= busy;
        if (busy_prev && !busy) fall_cyc <= cyc;
        if (flush && busy) viol <= viol + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_flush(input int lim, output int n, output bit ok);
        n = 0;
        ok = 1'b0;
        while (n < lim && !ok) begin
            @(negedge clk);
            n++;
            if (flush) ok = 1'b1;
        end
    endtask

    task automatic wait_idle(output bit ok);
        int n;
        n = 0;
        while (n < 200 && active) begin
            @(negedge clk);
            n++;
        end
        ok = !active;
    endtask

    task automatic grant_once(input logic [3:0] v, output logic [1:0] id, output logic [3:0] ack, output bit ok);
        int n;
        bit ok1, ok2;
        req_valid = v;
        wait_flush(FRAME + 20, n, ok1);
        id = grant_id;
        ack = req_ack;
        req_valid = '0;
        wait_idle(ok2);
        ok = ok1 && ok2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int nf;
        req_valid = '0;
        do_reset();
        checks++;
        if ({req_ack, to_sent, flush, grant_id, active, timeout_err} !== 15'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected 0", {req_ack, to_sent, flush, grant_id, active, timeout_err});
        end
        checks++;
        if (dut.state_q !== uart_pkg::IDLE) begin
            failures++;
            $display("FAIL reset_state: got %0d expected %0d", dut.state_q, uart_pkg::IDLE);
        end
        nf = 0;
        repeat (20) begin
            @(negedge clk);
            if (flush) nf++;
        end
        checks++;
        if (nf !== 0) begin
            failures++;
            $display("FAIL idle_no_flush: got %0d flushes expected 0", nf);
        end
    endtask

    task automatic test_single();
        int n;
        bit ok;
        req_data[6:0] = 7'd115;
        req_valid = 4'b0001;
        wait_flush(5, n, ok);
        checks++;
        if (!ok || n != 1) begin
            failures++;
            $display("FAIL single_latency: got %0d cycles (seen %0d) expected 1", n, ok);
        end
        checks++;
        if ({req_ack, to_sent, grant_id, active} !== {4'b0001, 7'd115, 2'd0, 1'b1}) begin
            failures++;
            $display("FAIL single_grant: got ack=%b data=%0d id=%0d act=%b expected ack=0001 data=115 id=0 act=1", req_ack, to_sent, grant_id, active);
        end
        req_valid = '0;
        @(negedge clk);
        checks++;
        if ({req_ack, flush} !== 5'd0 || to_sent !== 7'd115) begin
            failures++;
            $display("FAIL single_pulse: got ack=%b flush=%b data=%0d expected ack=0000 flush=0 data=115", req_ack, flush, to_sent);
        end
        n = 0;
        while (n < FRAME + 10 && !(busy_prev && !busy)) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (active !== 1'b1) begin
            failures++;
            $display("FAIL single_active_hold: got %b expected 1 when busy falls", active);
        end
        @(negedge clk);
        checks++;
        if (active !== 1'b0) begin
            failures++;
            $display("FAIL single_active_fall: got %b expected 0 one cycle after busy falls", active);
        end
    endtask

    task automatic test_round_robin();
        int n;
        bit ok;
        logic [1:0] exp_id;
        do_reset();
        req_data = {7'd68, 7'd67, 7'd66, 7'd65};
        req_valid = 4'b1111;
        viol = 0;
        for (int k = 0; k < 5; k++) begin
            exp_id = 2'(k % 4);
            wait_flush(FRAME + 10, n, ok);
            checks++;
            if (!ok || (k > 0 && n != FRAME + 2)) begin
                failures++;
                $display("FAIL rr_gap%0d: got %0d expected %0d", k, n + 1, FRAME + 3);
            end
            checks++;
            if ({grant_id, req_ack, to_sent} !== {exp_id, 4'(1) << exp_id, 7'(65 + exp_id)}) begin
                failures++;
                $display("FAIL rr_grant%0d: got id=%0d ack=%b data=%0d expected id=%0d", k, grant_id, req_ack, to_sent, exp_id);
            end
            if (k > 0) begin
                checks++;
                if (cyc - fall_cyc != 2) begin
                    failures++;
                    $display("FAIL rr_fall_to_flush%0d: got %0d edges expected 2", k, cyc - fall_cyc);
                end
            end
            @(negedge clk);
            checks++;
            if (req_ack !== 4'b0000) begin
                failures++;
                $display("FAIL rr_ack_width%0d: got %b expected 0000", k, req_ack);
            end
        end
        req_valid = '0;
        wait_idle(ok);
        checks++;
        if (!ok || viol != 0) begin
            failures++;
            $display("FAIL rr_flush_while_busy: got %0d expected 0 (idle=%0d)", viol, ok);
        end
    endtask

    task automatic test_wrap();
        logic [1:0] id;
        logic [3:0] ack;
        bit ok;
        grant_once(4'b0100, id, ack, ok);
        checks++;
        if (!ok || id !== 2'd2) begin
            failures++;
            $display("FAIL wrap_setup: got id=%0d ok=%0d expected id=2", id, ok);
        end
        grant_once(4'b1001, id, ack, ok);
        checks++;
        if (!ok || id !== 2'd3 || ack !== 4'b1000) begin
            failures++;
            $display("FAIL wrap_first: got id=%0d ack=%b expected id=3 ack=1000", id, ack);
        end
        grant_once(4'b1001, id, ack, ok);
        checks++;
        if (!ok || id !== 2'd0 || ack !== 4'b0001) begin
            failures++;
            $display("FAIL wrap_second: got id=%0d ack=%b expected id=0 ack=0001", id, ack);
        end
        grant_once(4'b0001, id, ack, ok);
        checks++;
        if (!ok || id !== 2'd0 || ack !== 4'b0001) begin
            failures++;
            $display("FAIL wrap_only0: got id=%0d ack=%b expected id=0 ack=0001", id, ack);
        end
    endtask

    task automatic test_timeout();
        int n;
        bit ok;
        logic [1:0] id;
        logic [3:0] ack;
        stub_en = 1'b0;
        busy_man = 1'b0;
        req_valid = 4'b0010;
        wait_flush(5, n, ok);
        req_valid = '0;
        n = 0;
        while (n < 40 && !timeout_err) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!ok || n != 17) begin
            failures++;
            $display("FAIL timeout_delay: got %0d cycles after flush expected 17", n);
        end
        checks++;
        if (active !== 1'b0) begin
            failures++;
            $display("FAIL timeout_active: got %b expected 0", active);
        end
        @(negedge clk);
        checks++;
        if (timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_pulse: got %b expected 0", timeout_err);
        end
        stub_en = 1'b1;
        grant_once(4'b0100, id, ack, ok);
        checks++;
        if (!ok || id !== 2'd2 || ack !== 4'b0100) begin
            failures++;
            $display("FAIL timeout_recover: got id=%0d ack=%b expected id=2 ack=0100", id, ack);
        end
    endtask

    task automatic test_reset_mid_frame();
        int n;
        bit ok;
        req_valid = 4'b0001;
        wait_flush(5, n, ok);
        req_valid = '0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (!busy || {req_ack, to_sent, flush, grant_id, active, timeout_err} !== 15'd0) begin
            failures++;
            $display("FAIL midreset_outputs: got %h busy=%b expected 0 busy=1", {req_ack, to_sent, flush, grant_id, active, timeout_err}, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 4'b0001;
        viol = 0;
        wait_flush(FRAME + 10, n, ok);
        checks++;
        if (!ok || cyc - fall_cyc != 1 || viol != 0) begin
            failures++;
            $display("FAIL midreset_grant: got %0d edges after busy fall (seen %0d, busy flushes %0d) expected 1", cyc - fall_cyc, ok, viol);
        end
        checks++;
        if (req_ack !== 4'b0001 || grant_id !== 2'd0) begin
            failures++;
            $display("FAIL midreset_ack: got ack=%b id=%0d expected ack=0001 id=0", req_ack, grant_id);
        end
        req_valid = '0;
        wait_idle(ok);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_timeout();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
